// File: rtl/qed_i_queue.sv
// QED instruction queue: records non-NOP original-mode instructions and replays
// them in order during duplicate execution. Pass-through and head read are combinational.
module qed_i_queue #(
    parameter int                DATA_W     = 32,
    parameter int                DEPTH_LOG2 = 8,
    parameter logic [6:0]        NOP_OPC    = 7'h7F,
    parameter logic [DATA_W-1:0] NOP_WORD   = DATA_W'(32'h0000007F)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exec_dup,
    input  logic                  IF_stall,
    input  logic                  flush,
    input  logic [DATA_W-1:0]     ifu_qed_instruction,
    output logic [DATA_W-1:0]     qic_qimux_instruction,
    output logic                  vld_out,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  q_empty,
    output logic                  q_full,
    output logic                  overflow_err,
    output logic                  dup_done
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2:0]   wr_ptr;
    logic [DEPTH_LOG2:0]   rd_ptr;
    logic                  is_nop;
    logic                  go;
    logic                  push;
    logic                  pop;
    logic                  ovf_set;

    // Extra wrap bit lets all DEPTH entries be used with exact full/empty.
    assign count   = wr_ptr - rd_ptr;
    assign q_empty = (wr_ptr == rd_ptr);
    assign q_full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

    assign is_nop  = (ifu_qed_instruction[6:0] == NOP_OPC);
    assign go      = ~rst & ~flush & ~IF_stall;
    assign push    = go & ~exec_dup & ~is_nop & ~q_full;
    assign pop     = go &  exec_dup & ~q_empty;
    assign ovf_set = go & ~exec_dup & ~is_nop &  q_full;

    always_comb begin
        qic_qimux_instruction = NOP_WORD;
        vld_out               = 1'b0;
        if (push) begin
            qic_qimux_instruction = ifu_qed_instruction;
            vld_out               = 1'b1;
        end else if (pop) begin
            qic_qimux_instruction = mem[rd_ptr[DEPTH_LOG2-1:0]];
            vld_out               = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= ifu_qed_instruction;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            overflow_err <= 1'b0;
            dup_done     <= 1'b0;
        end else if (flush) begin
            // Flush clears pointers only; the overflow flag survives until reset.
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            dup_done <= 1'b0;
        end else begin
            dup_done <= pop && (count == (DEPTH_LOG2 + 1)'(1));
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (ovf_set) begin
                overflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_qed_i_queue.sv
// Scoreboard bench for qed_i_queue at depth 4: stimulus queues expected valid words,
// a negedge monitor pops and compares them; status flags are checked directly.
module tb_qed_i_queue;

    localparam int          DW  = 32;
    localparam int          DL2 = 2;
    localparam logic [31:0] NOP = 32'h0000007F;

    logic            clk = 1'b0;
    logic            rst;
    logic            exec_dup;
    logic            IF_stall;
    logic            flush;
    logic [DW-1:0]   ifu_qed_instruction;
    logic [DW-1:0]   qic_qimux_instruction;
    logic            vld_out;
    logic [DL2:0]    count;
    logic            q_empty;
    logic            q_full;
    logic            overflow_err;
    logic            dup_done;

    int n_checks = 0;
    int n_pass   = 0;
    logic [DW-1:0] exp_q [$];

    always #5 clk = ~clk;

    qed_i_queue #(.DATA_W(DW), .DEPTH_LOG2(DL2)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .exec_dup              (exec_dup),
        .IF_stall              (IF_stall),
        .flush                 (flush),
        .ifu_qed_instruction   (ifu_qed_instruction),
        .qic_qimux_instruction (qic_qimux_instruction),
        .vld_out               (vld_out),
        .count                 (count),
        .q_empty               (q_empty),
        .q_full                (q_full),
        .overflow_err          (overflow_err),
        .dup_done              (dup_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every valid output must match the oldest expected word.
    always @(negedge clk) begin
        if (vld_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_vld: got %h expected no valid output", qic_qimux_instruction);
            end else begin
                chk("scoreboard_data", qic_qimux_instruction, exp_q.pop_front());
            end
        end
    end

    // Drives one cycle starting just after a posedge; returns just after the next posedge.
    task automatic step(input logic dup, input logic stall, input logic fl, input logic r,
                        input logic [31:0] ins, input logic ev, input logic [31:0] ed);
        exec_dup            = dup;
        IF_stall            = stall;
        flush               = fl;
        rst                 = r;
        ifu_qed_instruction = ins;
        if (ev) exp_q.push_back(ed);
        @(negedge clk);
        if (!ev) begin
            chk("idle_vld", {31'b0, vld_out}, 32'd0);
            chk("idle_word", qic_qimux_instruction, NOP);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_w(input logic [31:0] w);
        step(1'b0, 1'b0, 1'b0, 1'b0, w, 1'b1, w);
    endtask

    task automatic pop_w(input logic [31:0] w);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, w);
    endtask

    task automatic pop_none();
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic sb_drained(input string name);
        chk(name, exp_q.size(), 32'd0);
    endtask

    initial begin
        logic [31:0] fw [4];
        fw[0] = 32'hAAAA0001; fw[1] = 32'hBBBB0002; fw[2] = 32'hCCCC0003; fw[3] = 32'hDDDD0004;

        exec_dup = 0; IF_stall = 0; flush = 0; rst = 1; ifu_qed_instruction = 0;
        @(posedge clk); #1;
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h13, 1'b0, 32'h0);
        chk("rst_count", count, 0);
        chk("rst_empty", q_empty, 1);
        chk("rst_full", q_full, 0);
        chk("rst_ovf", overflow_err, 0);
        chk("rst_done", dup_done, 0);

        // Basic record and replay
        push_w(32'h00000013); push_w(32'h00100093); push_w(32'h00200113);
        chk("t1_count3", count, 3);
        pop_w(32'h00000013); pop_w(32'h00100093);
        chk("t1_done_early", dup_done, 0);
        pop_w(32'h00200113);
        chk("t1_done_pulse", dup_done, 1);
        chk("t1_empty", q_empty, 1);
        pop_none();
        chk("t1_done_single", dup_done, 0);
        sb_drained("t1_sb");

        // Full and overflow
        for (int i = 0; i < 4; i++) push_w(fw[i]);
        chk("t2_full", q_full, 1);
        chk("t2_count4", count, 4);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'hEEEE0005, 1'b0, 32'h0);
        chk("t2_ovf", overflow_err, 1);
        chk("t2_count_after_ovf", count, 4);
        for (int i = 0; i < 4; i++) pop_w(fw[i]);
        chk("t2_ovf_sticky", overflow_err, 1);
        chk("t2_empty", q_empty, 1);
        sb_drained("t2_sb");

        // Alternating push/pop across pointer wrap
        for (int i = 0; i < 5; i++) begin
            push_w(32'h5000_0100 + i);
            chk("t3_count1", count, 1);
            chk("t3_not_full", q_full, 0);
            pop_w(32'h5000_0100 + i);
            chk("t3_count0", count, 0);
        end
        sb_drained("t3_sb");

        // NOP word and stall
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000007F, 1'b0, 32'h0);
        chk("t4_nop_count", count, 0);
        push_w(32'h00300193);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h00400213, 1'b0, 32'h0);
        chk("t4_stall_push_count", count, 1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("t4_stall_pop_count", count, 1);
        pop_w(32'h00300193);
        sb_drained("t4_sb");

        // Flush with exec_dup asserted
        push_w(32'h01000013); push_w(32'h02000013); push_w(32'h03000013);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("t5_count", count, 0);
        chk("t5_empty", q_empty, 1);
        chk("t5_done", dup_done, 0);
        chk("t5_ovf_kept", overflow_err, 1);
        pop_none();
        chk("t5_done_after", dup_done, 0);
        sb_drained("t5_sb");

        // Reset mid-drain
        push_w(32'h0A000013); push_w(32'h0B000013);
        pop_w(32'h0A000013);
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0);
        chk("t6_count", count, 0);
        chk("t6_done", dup_done, 0);
        chk("t6_ovf_cleared", overflow_err, 0);
        pop_none();
        chk("t6_done_after", dup_done, 0);
        sb_drained("t6_sb");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
